axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Arbitrates the single AXI read channel between the instruction fetch requester (ID 0) and the data load requester (ID 1).
- Sits between the PC/fetch logic, the mem stage and the top-level AXI master port.
- Issues AR beats with fixed IDs and steers R beats back by rid.
- Allows at most one outstanding read per ID, so one inst read and one data read may be in flight at the same time.

Parameters:
INST_ID, 4'd0, arid used for instruction reads
DATA_ID, 4'd1, arid used for data reads

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
inst_req  in  1  fetch wants a read; held until inst_gnt
inst_addr  in  32  fetch address, word aligned
inst_gnt  out  1  inst AR handshake completed this cycle
inst_rvalid  out  1  R beat with rid==INST_ID present
inst_rready  in  1  fetch accepts R beat
data_req  in  1  load wants a read; held until data_gnt
data_addr  in  32  load address
data_size  in  3  AXI arsize for the load (0/1/2)
data_gnt  out  1  data AR handshake completed this cycle
data_rvalid  out  1  R beat with rid==DATA_ID present
data_rready  in  1  mem stage accepts R beat
rdata_o  out  32  rdata passthrough, shared by both requesters
data_r_req  out  2  {data AR pending, data R outstanding}; nonzero while a load is in progress
arid  out  4  AXI
araddr  out  32  AXI
arsize  out  3  AXI
arlen/arburst/arlock/arcache/arprot  out  8/2/2/4/3  constants 0/2'b01/0/0/0
arvalid  out  1  AXI
arready  in  1  AXI
rid  in  4  AXI
rdata  in  32  AXI
rresp  in  2  AXI; ignored
rlast  in  1  AXI
rvalid  in  1  AXI
rready  out  1  AXI

Behaviour:
- Reset values: arvalid=0, arid=0, araddr=0, arsize=0, inst_out=0, data_out=0, AR FSM=AR_IDLE. All gnt/rvalid/rready outputs are 0.
- AR FSM states: AR_IDLE, AR_INST, AR_DATA.
- AR_IDLE transitions:
  - data_req && !data_out → AR_DATA.
  - Else inst_req && !inst_out → AR_INST.
  - Data has fixed priority when both are eligible in the same cycle.
- On entering AR_INST/AR_DATA, the arbiter registers arid/araddr/arsize and drives arvalid=1 starting the next cycle.
- arsize is 3'd2 for inst and data_size for data.
- While arvalid is high, arid/araddr/arsize must not change, regardless of requester inputs.
- On arvalid&&arready:
  - Pulse the matching *_gnt for one cycle.
  - Set the matching outstanding flag (inst_out/data_out).
  - Return to AR_IDLE.
- Minimum AR latency: req sampled in cycle N → arvalid in cycle N+1 → gnt in the arready cycle.
- A requester dropping its req while its AR is pending has no effect: the issued AR completes.
- R steering (combinational):
  - inst_rvalid = rvalid && rid==INST_ID.
  - data_rvalid = rvalid && rid==DATA_ID.
  - rready = (rid==INST_ID ? inst_rready : rid==DATA_ID ? data_rready : 1'b1).
  - Unknown IDs are drained.
- Outstanding flags:
  - A flag clears on rvalid&&rready&&rlast for its ID.
  - A new AR for an ID is blocked until that ID's flag is clear.
  - A flag set by a gnt and cleared by an R beat in the same cycle cannot occur, because the AR handshake for an ID is blocked while that ID is outstanding.
- Simultaneous events: an R beat for one ID and an AR handshake for the other ID in the same cycle are both honoured.
- data_r_req = {state==AR_DATA, data_out}. It clears the cycle after the data R handshake.
- Reset mid-transaction abandons all flags immediately. The system resets the AXI slave together with this block.

Optional Feature:
- Macro RD_ARB_RR_EN.
- When defined: round-robin arbitration in AR_IDLE. A 1-bit last_gnt register is set on data_gnt and cleared on inst_gnt, and the requester not granted last wins a tie. last_gnt resets to 1, so inst wins the first tie.
- When undefined: fixed data priority as described above.

Test Plan:
- Reset → arvalid=0, rready=0 with rvalid=0, data_r_req=2'b00, inst_gnt=data_gnt=0.
- inst_req=1, inst_addr=32'hbfc00000, arready=1 → arvalid next cycle with arid=0, arsize=2. inst_gnt pulses once. R rid=0 rdata=32'h3c1d0000 rlast=1 → inst_rvalid=1 and rdata_o=32'h3c1d0000. inst_out clears.
- inst_req and data_req asserted in the same cycle (data_addr=32'h80001000, data_size=0) → data AR issued first (arid=1, arsize=0), then inst AR. With RD_ARB_RR_EN and last_gnt=0 → data first; repeat the tie → inst first.
- arready held 0 for 5 cycles while inst_addr changes each cycle → araddr stays at the first sampled value. Exactly one gnt pulse occurs.
- Data outstanding, R beat rid=1 with data_rready=0 for 3 cycles → rready=0 and data_r_req=2'b01 held. data_rready=1 → handshake, then data_r_req=2'b00. A second data_req issues no AR before the flag clears.
- Inst and data both outstanding; R returns rid=1 then rid=0 (out of order) → each beat is routed only to its owner, and both flags clear.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// AXI read-address / read-data channel bundle between the read arbiter (master)
// and the top-level AXI port (slave).
interface axi_rd_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arsize, arlen, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arsize, arlen, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between instruction fetch (INST_ID) and data load (DATA_ID).
// Optional macro RD_ARB_RR_EN: round-robin tie-break instead of fixed data priority.
module axi_rd_arbiter #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    input  logic        inst_rready,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    output logic        data_gnt,
    output logic        data_rvalid,
    input  logic        data_rready,
    output logic [31:0] rdata_o,
    output logic [1:0]  data_r_req,
    axi_rd_arbiter_if.master axi
);

    localparam logic [1:0] AR_IDLE = 2'd0;
    localparam logic [1:0] AR_INST = 2'd1;
    localparam logic [1:0] AR_DATA = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        arvalid_r;
    logic [3:0]  arid_r;
    logic [31:0] araddr_r;
    logic [2:0]  arsize_r;
    logic        inst_out_r;
    logic        data_out_r;

    logic        inst_elig_s;
    logic        data_elig_s;
    logic        pick_data_s;
    logic        ar_hs_s;
    logic        inst_gnt_s;
    logic        data_gnt_s;
    logic        rid_inst_s;
    logic        rid_data_s;
    logic        rready_s;
    logic        r_last_hs_s;

    assign ar_hs_s     = arvalid_r && axi.arready;
    assign inst_gnt_s  = ar_hs_s && (state_r == AR_INST);
    assign data_gnt_s  = ar_hs_s && (state_r == AR_DATA);
    assign inst_elig_s = inst_req && !inst_out_r;
    assign data_elig_s = data_req && !data_out_r;

`ifdef RD_ARB_RR_EN
    logic last_gnt_r;

    // Remember which requester won last so the other one wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_r <= 1'b1;
        end else if (data_gnt_s) begin
            last_gnt_r <= 1'b1;
        end else if (inst_gnt_s) begin
            last_gnt_r <= 1'b0;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    assign pick_data_s = data_elig_s && (!inst_elig_s || !last_gnt_r);
`else
    assign pick_data_s = data_elig_s;
`endif

    // AR state machine next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            AR_IDLE: begin
                if (pick_data_s) begin
                    state_nxt_s = AR_DATA;
                end else if (inst_elig_s) begin
                    state_nxt_s = AR_INST;
                end else begin
                    state_nxt_s = AR_IDLE;
                end
            end
            AR_INST, AR_DATA: begin
                if (ar_hs_s) begin
                    state_nxt_s = AR_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = AR_IDLE;
        endcase
    end

    // State plus AR payload; the payload is captured only from IDLE so it stays frozen while arvalid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= AR_IDLE;
            arvalid_r <= 1'b0;
            arid_r    <= 4'd0;
            araddr_r  <= 32'd0;
            arsize_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == AR_IDLE) begin
                if (pick_data_s) begin
                    arvalid_r <= 1'b1;
                    arid_r    <= DATA_ID;
                    araddr_r  <= data_addr;
                    arsize_r  <= data_size;
                end else if (inst_elig_s) begin
                    arvalid_r <= 1'b1;
                    arid_r    <= INST_ID;
                    araddr_r  <= inst_addr;
                    arsize_r  <= 3'd2;
                end else begin
                    arvalid_r <= 1'b0;
                end
            end else if (ar_hs_s) begin
                arvalid_r <= 1'b0;
            end else begin
                arvalid_r <= arvalid_r;
            end
        end
    end

    assign rid_inst_s  = (axi.rid == INST_ID);
    assign rid_data_s  = (axi.rid == DATA_ID);
    assign r_last_hs_s = axi.rvalid && rready_s && axi.rlast;

    // R-channel steering by rid; beats with unknown IDs are accepted and dropped.
    always_comb begin
        rready_s = 1'b1;
        if (rid_inst_s) begin
            rready_s = inst_rready;
        end else if (rid_data_s) begin
            rready_s = data_rready;
        end else begin
            rready_s = 1'b1;
        end
    end

    // One outstanding read per ID: set on AR grant, cleared on the last R beat of that ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_out_r <= 1'b0;
            data_out_r <= 1'b0;
        end else begin
            if (inst_gnt_s) begin
                inst_out_r <= 1'b1;
            end else if (r_last_hs_s && rid_inst_s) begin
                inst_out_r <= 1'b0;
            end else begin
                inst_out_r <= inst_out_r;
            end
            if (data_gnt_s) begin
                data_out_r <= 1'b1;
            end else if (r_last_hs_s && rid_data_s) begin
                data_out_r <= 1'b0;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign inst_gnt    = inst_gnt_s;
    assign data_gnt    = data_gnt_s;
    assign inst_rvalid = axi.rvalid && rid_inst_s;
    assign data_rvalid = axi.rvalid && rid_data_s;
    assign rdata_o     = axi.rdata;
    assign data_r_req  = {(state_r == AR_DATA), data_out_r};

    assign axi.arid    = arid_r;
    assign axi.araddr  = araddr_r;
    assign axi.arsize  = arsize_r;
    assign axi.arvalid = arvalid_r;
    assign axi.arlen   = 8'd0;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'd0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.rready  = rready_s;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: the bench plays both requesters and the AXI slave.
module tb_axi_rd_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic        inst_rready;
    logic        data_req;
    logic [31:0] data_addr;
    logic [2:0]  data_size;
    logic        data_gnt;
    logic        data_rvalid;
    logic        data_rready;
    logic [31:0] rdata_o;
    logic [1:0]  data_r_req;

    int n_assert;
    int n_fail;

    axi_rd_arbiter_if axi ();

    axi_rd_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rready (inst_rready),
        .data_req    (data_req),
        .data_addr   (data_addr),
        .data_size   (data_size),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rready (data_rready),
        .rdata_o     (rdata_o),
        .data_r_req  (data_r_req),
        .axi         (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0]  first_id;
        logic [3:0]  second_id;
        n_assert = 0;
        n_fail   = 0;
`ifdef RD_ARB_RR_EN
        first_id = 4'd0;
`else
        first_id = 4'd1;
`endif
        second_id = (first_id == 4'd1) ? 4'd0 : 4'd1;

        rst = 1'b1; inst_req = 1'b0; inst_addr = 32'd0; inst_rready = 1'b0;
        data_req = 1'b0; data_addr = 32'd0; data_size = 3'd0; data_rready = 1'b0;
        axi.arready = 1'b0; axi.rid = 4'd0; axi.rdata = 32'd0; axi.rresp = 2'd0;
        axi.rlast = 1'b0; axi.rvalid = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_arvalid", {31'd0, axi.arvalid}, 32'd0);
        chk("rst_rready", {31'd0, axi.rready}, 32'd0);
        chk("rst_data_r_req", {30'd0, data_r_req}, 32'd0);
        chk("rst_inst_gnt", {31'd0, inst_gnt}, 32'd0);
        chk("rst_data_gnt", {31'd0, data_gnt}, 32'd0);
        chk("rst_araddr", axi.araddr, 32'd0);
        chk("rst_arlen_burst", {22'd0, axi.arlen, axi.arburst}, 32'h0000_0001);
        rst = 1'b0;
        tick();

        // Single instruction read
        inst_req = 1'b1; inst_addr = 32'hbfc0_0000; axi.arready = 1'b1;
        #1;
        chk("i1_arvalid_pre", {31'd0, axi.arvalid}, 32'd0);
        tick();
        chk("i1_arvalid", {31'd0, axi.arvalid}, 32'd1);
        chk("i1_arid", {28'd0, axi.arid}, 32'd0);
        chk("i1_araddr", axi.araddr, 32'hbfc0_0000);
        chk("i1_arsize", {29'd0, axi.arsize}, 32'd2);
        chk("i1_gnt", {31'd0, inst_gnt}, 32'd1);
        inst_req = 1'b0;
        tick();
        chk("i1_arvalid_post", {31'd0, axi.arvalid}, 32'd0);
        chk("i1_gnt_post", {31'd0, inst_gnt}, 32'd0);
        axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'h3c1d_0000; axi.rlast = 1'b1; inst_rready = 1'b1;
        #1;
        chk("i1_inst_rvalid", {31'd0, inst_rvalid}, 32'd1);
        chk("i1_data_rvalid", {31'd0, data_rvalid}, 32'd0);
        chk("i1_rdata", rdata_o, 32'h3c1d_0000);
        chk("i1_rready", {31'd0, axi.rready}, 32'd1);
        tick();

        // AR held by arready=0: payload frozen, one grant only
        axi.rvalid = 1'b0; inst_req = 1'b1; inst_addr = 32'hbfc0_0004; axi.arready = 1'b0;
        tick();
        chk("h_arvalid", {31'd0, axi.arvalid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            inst_addr = 32'hbfc0_0100 + 32'(i * 4);
            #1;
            chk("h_araddr_hold", axi.araddr, 32'hbfc0_0004);
            chk("h_gnt_hold", {31'd0, inst_gnt}, 32'd0);
            tick();
        end
        axi.arready = 1'b1;
        #1;
        chk("h_gnt", {31'd0, inst_gnt}, 32'd1);
        chk("h_araddr", axi.araddr, 32'hbfc0_0004);
        inst_req = 1'b0;
        tick();
        chk("h_arvalid_post", {31'd0, axi.arvalid}, 32'd0);
        chk("h_gnt_post", {31'd0, inst_gnt}, 32'd0);
        axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'hcafe_f00d; axi.rlast = 1'b1;
        #1;
        chk("h_inst_rvalid", {31'd0, inst_rvalid}, 32'd1);
        tick();
        axi.rvalid = 1'b0;

        // Tie: data wins (fixed priority, or round-robin after an inst grant)
        inst_req = 1'b1; inst_addr = 32'hbfc0_0200;
        data_req = 1'b1; data_addr = 32'h8000_1000; data_size = 3'd0;
        #1;
        chk("t1_data_r_req_pre", {30'd0, data_r_req}, 32'd0);
        tick();
        chk("t1_arid_data", {28'd0, axi.arid}, 32'd1);
        chk("t1_araddr_data", axi.araddr, 32'h8000_1000);
        chk("t1_arsize_data", {29'd0, axi.arsize}, 32'd0);
        chk("t1_data_gnt", {31'd0, data_gnt}, 32'd1);
        chk("t1_inst_gnt", {31'd0, inst_gnt}, 32'd0);
        chk("t1_data_r_req_ar", {30'd0, data_r_req}, 32'd2);
        data_req = 1'b0;
        tick();
        chk("t1_arvalid_gap", {31'd0, axi.arvalid}, 32'd0);
        chk("t1_data_r_req_out", {30'd0, data_r_req}, 32'd1);
        tick();
        chk("t1_arid_inst", {28'd0, axi.arid}, 32'd0);
        chk("t1_araddr_inst", axi.araddr, 32'hbfc0_0200);
        chk("t1_arsize_inst", {29'd0, axi.arsize}, 32'd2);
        chk("t1_inst_gnt2", {31'd0, inst_gnt}, 32'd1);
        inst_req = 1'b0;
        tick();

        // Out-of-order return: rid=1 then rid=0
        axi.rvalid = 1'b1; axi.rid = 4'd1; axi.rdata = 32'h1111_1111; axi.rlast = 1'b1;
        inst_rready = 1'b1; data_rready = 1'b1;
        #1;
        chk("o_data_rvalid", {31'd0, data_rvalid}, 32'd1);
        chk("o_inst_rvalid_n", {31'd0, inst_rvalid}, 32'd0);
        chk("o_rdata1", rdata_o, 32'h1111_1111);
        tick();
        axi.rid = 4'd0; axi.rdata = 32'h2222_2222;
        #1;
        chk("o_data_r_req_clr", {30'd0, data_r_req}, 32'd0);
        chk("o_inst_rvalid", {31'd0, inst_rvalid}, 32'd1);
        chk("o_data_rvalid_n", {31'd0, data_rvalid}, 32'd0);
        chk("o_rdata0", rdata_o, 32'h2222_2222);
        tick();
        axi.rvalid = 1'b0;

        // Inst outstanding, then data AR handshake in the same cycle as the inst R beat
        inst_req = 1'b1; inst_addr = 32'hbfc0_0400;
        tick();
        chk("s_inst_gnt", {31'd0, inst_gnt}, 32'd1);
        inst_req = 1'b0;
        tick();
        data_req = 1'b1; data_addr = 32'h8000_2000; data_size = 3'd2;
        tick();
        chk("s_arid", {28'd0, axi.arid}, 32'd1);
        chk("s_araddr", axi.araddr, 32'h8000_2000);
        chk("s_arsize", {29'd0, axi.arsize}, 32'd2);
        axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rlast = 1'b1; axi.rdata = 32'h4444_4444;
        data_addr = 32'h8000_3000;
        #1;
        chk("s_data_gnt", {31'd0, data_gnt}, 32'd1);
        chk("s_inst_rvalid", {31'd0, inst_rvalid}, 32'd1);
        chk("s_rready", {31'd0, axi.rready}, 32'd1);
        tick();

        // Data R beat stalled by data_rready=0; second data_req blocked meanwhile
        axi.rid = 4'd1; axi.rdata = 32'h3333_3333; data_rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_rready", {31'd0, axi.rready}, 32'd0);
            chk("st_data_r_req", {30'd0, data_r_req}, 32'd1);
            chk("st_arvalid", {31'd0, axi.arvalid}, 32'd0);
            chk("st_data_rvalid", {31'd0, data_rvalid}, 32'd1);
            tick();
        end
        data_rready = 1'b1;
        #1;
        chk("st_rready_go", {31'd0, axi.rready}, 32'd1);
        tick();
        axi.rvalid = 1'b0;
        #1;
        chk("st_data_r_req_clr", {30'd0, data_r_req}, 32'd0);
        chk("st_arvalid_blocked", {31'd0, axi.arvalid}, 32'd0);
        axi.arready = 1'b0;
        tick();
        chk("st_arvalid_reissue", {31'd0, axi.arvalid}, 32'd1);
        chk("st_araddr_reissue", axi.araddr, 32'h8000_3000);
        chk("st_data_r_req_ar", {30'd0, data_r_req}, 32'd2);
        chk("st_data_gnt_wait", {31'd0, data_gnt}, 32'd0);
        axi.arready = 1'b1;
        #1;
        chk("st_data_gnt", {31'd0, data_gnt}, 32'd1);
        data_req = 1'b0;
        tick();
        chk("st_data_r_req_out", {30'd0, data_r_req}, 32'd1);

        // Unknown ID is drained without touching any flag
        axi.rvalid = 1'b1; axi.rid = 4'd5; axi.rlast = 1'b1; inst_rready = 1'b0; data_rready = 1'b0;
        #1;
        chk("u_rready", {31'd0, axi.rready}, 32'd1);
        chk("u_inst_rvalid", {31'd0, inst_rvalid}, 32'd0);
        chk("u_data_rvalid", {31'd0, data_rvalid}, 32'd0);
        tick();
        chk("u_data_r_req", {30'd0, data_r_req}, 32'd1);
        axi.rid = 4'd1; data_rready = 1'b1;
        tick();
        axi.rvalid = 1'b0;
        #1;
        chk("u_data_r_req_clr", {30'd0, data_r_req}, 32'd0);

        // Second tie after a data grant: round-robin favours inst, fixed priority still data
        inst_req = 1'b1; inst_addr = 32'hbfc0_0500;
        data_req = 1'b1; data_addr = 32'h8000_4000; data_size = 3'd1;
        tick();
        chk("t2_arid_first", {28'd0, axi.arid}, {28'd0, first_id});
        chk("t2_araddr_first", axi.araddr, (first_id == 4'd1) ? 32'h8000_4000 : 32'hbfc0_0500);
        chk("t2_arsize_first", {29'd0, axi.arsize}, (first_id == 4'd1) ? 32'd1 : 32'd2);
        if (first_id == 4'd1) data_req = 1'b0;
        else inst_req = 1'b0;
        tick();
        tick();
        chk("t2_arid_second", {28'd0, axi.arid}, {28'd0, second_id});
        chk("t2_araddr_second", axi.araddr, (second_id == 4'd1) ? 32'h8000_4000 : 32'hbfc0_0500);
        chk("t2_gnt_second", {30'd0, data_gnt, inst_gnt}, (second_id == 4'd1) ? 32'd2 : 32'd1);
        inst_req = 1'b0; data_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
